// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchroniser, mid-bit 3-sample majority vote,
// parity/stop checking, one-cycle valid strobe with error flags.
module uart_rx #(
    parameter int CLK_FREQ  = 48000000,
    parameter int BAUD_RATE = 480000,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] LP_S0   = CW'(HALF - 1);
    localparam logic [CW-1:0] LP_S1   = CW'(HALF);
    localparam logic [CW-1:0] LP_DEC  = CW'(HALF + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_smp0;
    logic          r_smp1;
    logic          r_perr;

    logic          w_rx_s;
    logic          w_bit;
    logic          w_decide;
    logic          w_exp_par;
    logic          w_counting;

    assign w_rx_s     = r_sync2;
    assign w_bit      = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);
    assign w_decide   = (r_cnt == LP_DEC);
    assign w_exp_par  = (PARITY != 0) ? ~^r_shift : ^r_shift;
    assign w_counting = (r_state != S_IDLE) && (r_state != S_BREAK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_smp0     <= 1'b0;
            r_smp1     <= 1'b0;
            r_perr     <= 1'b0;
            data_rx    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (w_counting) begin
                r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
                if (r_cnt == LP_S0) r_smp0 <= w_rx_s;
                if (r_cnt == LP_S1) r_smp1 <= w_rx_s;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= S_START;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            r_state <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_perr  <= (w_bit != w_exp_par);
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        rx_valid   <= 1'b1;
                        data_rx    <= r_shift;
                        parity_err <= r_perr;
                        frame_err  <= ~w_bit;
                        // leave mid-stop so a back-to-back start edge is seen
                        if (w_bit) begin
                            r_state <= S_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            r_state <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive stage that pairs with the team's UART transmitter (frame: START(0), DATA[7:0] LSB first, PARITY, STOP(1)).
- Synchronises the asynchronous rx line and samples each bit at mid-bit with a 3-sample majority vote.
- Checks parity and stop bit, then delivers the byte with a one-cycle valid strobe and error flags.
- Sits between the board RX pin and the FPGA command/data logic.

Parameters:
- CLK_FREQ, 48000000, system clock frequency in Hz.
- BAUD_RATE, 480000, line bit rate.
- PARITY, 0, 0 = even (parity bit = XOR of data), 1 = odd (parity bit = inverted XOR).
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE, bit window in clocks; must be >= 8.
- HALF (localparam), CLKS_PER_BIT/2, integer division.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rx  in  1  UART line, asynchronous to clk, idles high.
- data_rx  out  8  last received byte.
- rx_valid  out  1  one-cycle strobe; data_rx and the error flags are valid in this cycle.
- parity_err  out  1  parity mismatch on the last frame.
- frame_err  out  1  stop bit sampled low on the last frame.
- rx_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous):
  - data_rx = 0x00; rx_valid, parity_err, frame_err, rx_busy = 0.
  - Both synchroniser flops = 1; state = IDLE; counters = 0.
- Synchroniser: two-flop chain; rx_s lags rx by 2 clocks. All logic uses rx_s only.
- Bit window counter cnt:
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0; each wrap starts the next bit window.
  - Samples are taken at cnt = HALF-1, HALF and HALF+1.
  - Bit value = majority of the 3 samples; the decision is made in the cycle cnt = HALF+1.
- IDLE: when rx_s == 0, set cnt = 0, go to START; rx_busy rises the next cycle.
- START:
  - Decision 0: go to DATA with bit_idx = 0.
  - Decision 1 (false start/glitch): go to IDLE; no rx_valid.
- DATA:
  - Each decision shifts the bit into the shift register LSB first.
  - After bit_idx 7 is decided, go to PARITY.
- PARITY: at the decision, compute expected = PARITY ? ~^shift : ^shift; perr = (sample != expected). Go to STOP.
- STOP:
  - At the decision, ferr = (sample == 0).
  - Next cycle: rx_valid = 1 for exactly one clock; data_rx = shift, parity_err = perr, frame_err = ferr, all registered in that same cycle.
  - The byte is delivered even when flags are set. data_rx and flags hold until the next rx_valid.
  - Stop = 1: go to IDLE immediately (mid-stop bit), so a back-to-back start edge is caught.
  - Stop = 0: go to BREAK.
- BREAK: rx_busy stays 1; wait for rx_s == 1, then go to IDLE. No frames are accepted while the line is held low.
- Latency: rx_valid asserts 2 (sync) + 10*CLKS_PER_BIT + HALF + 2 clocks after the rx falling edge of the start bit.
- Timing tolerance: transmitter bit period may differ from CLKS_PER_BIT by up to ±3% with no errors.
- Glitches: a single-cycle glitch on any sample point is rejected by the majority vote.
- Reset mid-frame: the frame is aborted, outputs return to reset values, no rx_valid; the next full frame is received normally.

Test Plan:
1. Even parity, frame 0xA5 with parity bit 0, stop 1, exact bit timing -> single rx_valid pulse, data_rx = 0xA5, parity_err = 0, frame_err = 0, rx_busy back to 0 after the pulse.
2. Even parity, frame 0x01 with parity bit 0 (correct is 1) -> rx_valid, data_rx = 0x01, parity_err = 1, frame_err = 0.
3. Frame 0x7E with stop bit 0, then line low for 3 bit times -> rx_valid with frame_err = 1, rx_busy stays 1 until rx returns high; a following 0x3C frame is received clean.
4. rx low for 10 clocks, then high; plus a 1-clock low pulse at HALF inside a data bit of frame 0xFF -> no rx_valid for the runt start; the frame decodes as 0xFF with no errors.
5. PARITY=1, loopback from the transmitter sending 0x00, 0xFF, 0x5A back-to-back with bit period CLKS_PER_BIT+1 -> exactly three rx_valid pulses, correct bytes, all flags 0.
6. Reset asserted after 4 data bits of frame 0x99 -> all outputs at reset values, no rx_valid; the next frame 0xC3 is received correctly.
